// File: rtl/cs_round_mix.sv
// One CS-Cipher round: key add, then three sub-layers of constant XOR, M on four
// 16-bit words and byte transpose, with NUM_M M instances time-multiplexed per cycle.
`timescale 1ns/1ps

module m_module (
    input  logic [15:0] x,
    output logic [15:0] y_c
);
    function automatic logic [3:0] f_box(input logic [3:0] v);
        logic [3:0] r;
        unique case (v)
            4'h0: r = 4'hf;  4'h1: r = 4'hd;  4'h2: r = 4'hb;  4'h3: r = 4'hb;
            4'h4: r = 4'h7;  4'h5: r = 4'h5;  4'h6: r = 4'h7;  4'h7: r = 4'h7;
            4'h8: r = 4'he;  4'h9: r = 4'hd;  4'ha: r = 4'ha;  4'hb: r = 4'hb;
            4'hc: r = 4'he;  4'hd: r = 4'hd;  4'he: r = 4'he;  default: r = 4'hf;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] g_box(input logic [3:0] v);
        logic [3:0] r;
        unique case (v)
            4'h0: r = 4'ha;  4'h1: r = 4'h6;  4'h2: r = 4'h0;  4'h3: r = 4'h2;
            4'h4: r = 4'hb;  4'h5: r = 4'he;  4'h6: r = 4'h1;  4'h7: r = 4'h8;
            4'h8: r = 4'hd;  4'h9: r = 4'h4;  4'ha: r = 4'h5;  4'hb: r = 4'h3;
            4'hc: r = 4'hf;  4'hd: r = 4'hc;  4'he: r = 4'h7;  default: r = 4'h9;
        endcase
        return r;
    endfunction

    // 8-bit permutation P: three-round nibble Feistel over f and g
    function automatic logic [7:0] p_perm(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] r;
        logic [3:0] l;
        t = v[7:4] ^ f_box(v[3:0]);
        r = v[3:0] ^ g_box(t);
        l = t ^ f_box(r);
        return {l, r};
    endfunction

    logic [7:0] xl_rot;
    logic [7:0] xl_phi;

    assign xl_rot = {x[14:8], x[15]};
    assign xl_phi = (xl_rot & 8'h55) ^ x[15:8];
    assign y_c    = {p_perm(xl_phi ^ x[7:0]), p_perm(xl_rot ^ x[7:0])};
endmodule

module cs_round_mix #(
    parameter int unsigned NUM_M = 1,
    parameter logic [63:0] C0    = 64'hB7E151628AED2A6A,
    parameter logic [63:0] C1    = 64'hBF7158809CF4F3C7,
    parameter logic [63:0] C2    = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_state,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_state
);
    localparam int unsigned W_BLK  = 64;
    localparam int unsigned W_WORD = 16;

    generate
        if (!(NUM_M == 1 || NUM_M == 2 || NUM_M == 4)) begin : g_bad_num_m
            $error("cs_round_mix: NUM_M must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_BLK-1:0]   s_q, s_d;
    logic [1:0]         sub_q, sub_d;
    logic [1:0]         word_q, word_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [W_BLK-1:0]   c_sel;
    logic [1:0]         m_idx [NUM_M];
    logic [5:0]         m_lsb [NUM_M];
    logic [W_WORD-1:0]  m_in  [NUM_M];
    logic [W_WORD-1:0]  m_out [NUM_M];
    logic               last_word;

    function automatic logic [63:0] transpose(input logic [63:0] v);
        return {v[63:56], v[47:40], v[31:24], v[15:8],
                v[55:48], v[39:32], v[23:16], v[7:0]};
    endfunction

    always_comb begin
        unique case (sub_q)
            2'd0:    c_sel = C0;
            2'd1:    c_sel = C1;
            default: c_sel = C2;
        endcase
    end

    // Lane k handles word word_q+k; word i lives at bits [63-16i -: 16]
    for (genvar k = 0; k < NUM_M; k++) begin : g_lane
        assign m_idx[k] = word_q + 2'(k);
        assign m_lsb[k] = 6'(48) - {m_idx[k], 4'b0000};
        assign m_in[k]  = s_q[m_lsb[k] +: W_WORD] ^ c_sel[m_lsb[k] +: W_WORD];
        m_module u_m (
            .x   (m_in[k]),
            .y_c (m_out[k])
        );
    end

    assign last_word = (3'(word_q) + 3'(NUM_M)) == 3'd4;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        sub_d   = sub_q;
        word_d  = word_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    s_d     = in_state ^ in_key;
                    sub_d   = 2'd0;
                    word_d  = 2'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned k = 0; k < NUM_M; k++) begin
                    s_d[m_lsb[k] +: W_WORD] = m_out[k];
                end
                word_d = 2'(3'(word_q) + 3'(NUM_M));
                // Transpose lands on the same edge as the sub-layer's last word
                if (last_word) begin
                    s_d = transpose(s_d);
                    if (sub_q == 2'd2) begin
                        state_d = ST_DONE;
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            sub_q       <= 2'd0;
            word_q      <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            sub_q       <= sub_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = s_q;
endmodule

// File: doc/cs_round_mix.md
Name: cs_round_mix

Overview:
- One CS-Cipher round datapath for a 64-bit block.
- Adds the 64-bit round key, then applies three mixing sub-layers. Each sub-layer is: constant XOR, the 16-bit M function on four words, then a byte transpose.
- Iterative: instantiates NUM_M copies of m_module and time-multiplexes them over the 12 word-evaluations per round.
- Sits directly downstream of the key schedule and upstream of the round controller. It is the sole consumer of m_module outputs.

Parameters:
- NUM_M, 1, number of m_module instances; legal values 1, 2, 4; compute cycles = 12/NUM_M.
- C0, 64'hB7E151628AED2A6A, constant XORed before M in sub-layer 0.
- C1, 64'hBF7158809CF4F3C7, constant XORed before M in sub-layer 1.
- C2, 64'h0, constant XORed before M in sub-layer 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block/key valid.
- in_ready  out  1  block can accept input.
- in_state  in  64  plaintext/intermediate block; byte a0 = [63:56].
- in_key  in  64  round key.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_state  out  64  round result.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; sub-layer counter and word counter to 0; state register to 0.
  - Outputs: in_ready=1, out_valid=0, out_state=0.
  - Reset mid-RUN or mid-DONE aborts the block. No output is produced for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load S <= in_state ^ in_key, clear counters, go to RUN.
  - RUN: in_ready=0. Each cycle processes NUM_M words of the current sub-layer j.
    - Word i (i=0..3) is S[63-16i -: 16]. Its M input is word ^ Cj[63-16i -: 16]. The result replaces the word; the m_module high byte is x[15:8].
    - Words are processed in ascending i, NUM_M per cycle.
    - On the cycle that writes the last word of a sub-layer, apply the byte transpose at that same edge: (a0,a1,a2,a3,a4,a5,a6,a7) -> (a0,a2,a4,a6,a1,a3,a5,a7).
    - After the transpose of sub-layer 2, go to DONE.
  - DONE: out_valid=1 and out_state=S. Hold both stable while out_ready=0. On out_ready=1, go to IDLE.
- Latency: input accepted at edge T gives out_valid=1 after edge T+12/NUM_M, i.e. 12, 6 or 3 cycles of RUN.
  - Throughput: one block per 12/NUM_M+2 cycles with out_ready held high.
- No overlap: in_valid while in RUN or DONE is ignored. Input is not captured and in_ready stays 0.
- DONE->IDLE requires one cycle, so in_ready rises the cycle after the output handshake. There is no same-cycle in/out bypass.
- out_state is registered and changes only at load and RUN edges. When not in DONE it shows the intermediate S; consumers must qualify it with out_valid.
- All XORs are 64-bit bitwise. There is no arithmetic and no carries.
- Illegal NUM_M (not 1, 2 or 4) causes elaboration failure via a static assertion.

Test Plan:
- Golden: in_state=64'h0123456789ABCDEF, in_key=64'h0, NUM_M=1, out_ready=1.
  - Required: out_valid rises exactly 12 cycles after the accept edge, stays high for exactly 1 cycle.
  - out_state equals the software model (key add, 3×[const XOR, M on 4 words, transpose]).
  - Repeat with NUM_M=2 (latency 6) and NUM_M=4 (latency 3); out_state must match bit-for-bit.
- Key add: in_state=in_key=64'hFFFF_FFFF_FFFF_FFFF vs in_state=in_key=64'h0.
  - Required: both give identical out_state, equal to the model of an all-zero block.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_valid and out_state are stable for all 5 cycles; in_ready=0 throughout.
  - in_ready=1 exactly one cycle after out_ready is asserted.
- Busy input: pulse in_valid with a different block at RUN cycle 4.
  - Required: it is ignored and the first block's result is unchanged.
  - A second block presented after in_ready returns is processed correctly.
- Reset mid-operation: assert rst_n=0 asynchronously at RUN cycle 7.
  - Required: outputs go immediately to in_ready=1, out_valid=0, out_state=0, with no spurious out_valid after release.
  - The next block yields the golden result.
- Back-to-back: present 8 random blocks with in_valid tied high and out_ready=1.
  - Required: 8 outputs in order, all matching the model, spaced 14 cycles apart (NUM_M=1).
